// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: request, response and data-RAM port bundle
// for the MEM-stage load/store initiator.
interface lsu_mem_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_excp;
  logic [ADDR_WIDTH-1:0] resp_badv;

  logic                  ram_ce;
  logic                  ram_we;
  logic [31:0]           ram_pc;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_sel;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_pc, req_addr, req_wdata,
    input  resp_ready, ram_rdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_excp, resp_badv,
    output ram_ce, ram_we, ram_pc, ram_addr, ram_sel, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_pc, req_addr, req_wdata,
    output resp_ready, ram_rdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_excp, resp_badv,
    input  ram_ce, ram_we, ram_pc, ram_addr, ram_sel, ram_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: MEM-stage load/store initiator for one data-RAM port.
// Define LSU_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module lsu_mem_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  lsu_mem_initiator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  accept;
  logic                  misal;
  logic                  issue;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [3:0]            st_sel;
  logic [DATA_WIDTH-1:0] st_wdata;

  assign accept = (state == IDLE) & ~rst & bus.req_valid;

`ifdef LSU_ALIGN_CHECK_EN
  assign misal =
    ((bus.req_size == 2'b01) & bus.req_addr[0]) |
    (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign issue = accept & ~misal;

  // Store byte strobes and lane-replicated write data by size
  always_comb begin
    st_sel   = 4'b1111;
    st_wdata = bus.req_wdata;
    unique case (1'b1)
      bus.req_size == 2'b00: begin
        st_sel   = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      bus.req_size == 2'b01: begin
        st_sel   = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction and sign/zero extension of the RAM read word
  always_comb begin
    ld_b    = 8'(bus.ram_rdata >> {off_q, 3'b000});
    ld_h    = off_q[1] ? bus.ram_rdata[31:16]
                       : bus.ram_rdata[15:0];
    ld_data = bus.ram_rdata;
    unique case (1'b1)
      size_q == 2'b00:
        ld_data = {{24{~uns_q & ld_b[7]}}, ld_b};
      size_q == 2'b01:
        ld_data = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = (issue & ~bus.req_we) ? RD_WAIT : RESP;
      end
      RD_WAIT: state_nxt = RESP;
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and RAM port outputs; RAM is driven only in the accept cycle
  always_comb begin
    bus.req_ready  = (state == IDLE) & ~rst;
    bus.resp_valid = (state == RESP);
    bus.ram_ce     = issue;
    bus.ram_we     = issue & bus.req_we;
    bus.ram_pc     = issue ? bus.req_pc : '0;
    bus.ram_addr   = issue ? {bus.req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    bus.ram_sel    = issue ? (bus.req_we ? st_sel : 4'b1111) : 4'b0000;
    bus.ram_wdata  = (issue & bus.req_we) ? st_wdata : '0;
  end

  // Load context at accept, response data once the RAM word arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      off_q   <= bus.req_addr[1:0];
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      rdata_q <= '0;
    end else if (state == RD_WAIT) begin
      rdata_q <= ld_data;
    end
  end

  assign bus.resp_rdata = rdata_q;

`ifdef LSU_ALIGN_CHECK_EN
  logic                  excp_q;
  logic [ADDR_WIDTH-1:0] badv_q;

  // Latch the fault flag and faulting address at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      excp_q <= 1'b0;
      badv_q <= '0;
    end else if (accept) begin
      excp_q <= misal;
      badv_q <= misal ? bus.req_addr : '0;
    end
  end

  assign bus.resp_excp = excp_q;
  assign bus.resp_badv = badv_q;
`else
  assign bus.resp_excp = 1'b0;
  assign bus.resp_badv = '0;
`endif

endmodule
